// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: source count defaults and FSM encodings.
package intr_ctrl_pkg;

    localparam int NSRC_DEF = 4;
    localparam int VW_DEF   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; valid flags a non-empty request vector.
module prio_enc #(
    parameter int NSRC = 4,
    parameter int VW   = 2
) (
    input  logic [NSRC-1:0] req,
    output logic [VW-1:0]   idx,
    output logic            valid
);

    // Scan high to low so the lowest set bit is the final assignment.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = VW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered interrupt controller: pending/enable registers, fixed priority, IDLE/REQ/SERV handshake.
// irq and vector are driven from registers only, so ack/eoi never reach irq combinationally.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int VW   = VW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_in,
    input  logic            ack,
    input  logic            eoi,
    output logic            irq,
    output logic [VW-1:0]   vector,
    output logic [NSRC-1:0] pending,
    output logic            in_service
);

    state_t          state, state_nxt;
    logic [NSRC-1:0] src_d;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] src_rise;
    logic [NSRC-1:0] pend_clr;
    logic [NSRC-1:0] eligible;
    logic [VW-1:0]   win_idx;
    logic            win_vld;
    logic            take_ack;

    assign src_rise = src & ~src_d;
    assign eligible = pending & mask;
    assign take_ack = (state == REQ) && ack;
    assign pend_clr = take_ack ? (NSRC'(1) << vector) : '0;

    prio_enc #(
        .NSRC (NSRC),
        .VW   (VW)
    ) u_prio_enc (
        .req   (eligible),
        .idx   (win_idx),
        .valid (win_vld)
    );

    // src_d tracks src even in reset so a line already high at release is not an edge.
    always_ff @(posedge clk) begin
        src_d <= src;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = REQ;
            REQ:     if (ack)     state_nxt = SERV;
            SERV:    if (eoi)     state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        irq        = (state == REQ);
        in_service = (state == SERV);
    end

    // A rising edge coinciding with the ack clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            mask    <= '0;
            vector  <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | src_rise;
            if (mask_we) begin
                mask <= mask_in;
            end
            if (state == IDLE && win_vld) begin
                vector <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: hand-computed expectations checked one cycle at a time.
`timescale 1ns/1ps
module tb_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] src;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [1:0] vector;
    logic [3:0] pending;
    logic       in_service;

    int n_chk  = 0;
    int n_pass = 0;

    intr_ctrl #(.NSRC(4), .VW(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .src        (src),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .ack        (ack),
        .eoi        (eoi),
        .irq        (irq),
        .vector     (vector),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one rising edge, then settle so outputs reflect post-edge state.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we = 1'b1;
        mask_in = m;
        step();
        mask_we = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic e_irq, input logic [1:0] e_vec,
                           input logic [3:0] e_pend, input logic e_serv);
        chk({tag, ".irq"},        irq,        e_irq);
        chk({tag, ".vector"},     vector,     e_vec);
        chk({tag, ".pending"},    pending,    e_pend);
        chk({tag, ".in_service"}, in_service, e_serv);
    endtask

    initial begin
        reset = 1'b1; src = '0; mask_we = 1'b0; mask_in = '0; ack = 1'b0; eoi = 1'b0;
        step(); step();
        chk_out("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        reset = 1'b0;
        step();

        // Single request: edge sets pending, irq follows one edge later, ack clears.
        write_mask(4'b0001);
        src = 4'b0001; step();
        chk_out("single.edge", 1'b0, 2'd0, 4'b0001, 1'b0);
        src = 4'b0000; step();
        chk_out("single.req", 1'b1, 2'd0, 4'b0001, 1'b0);
        step();
        chk("single.hold.irq", irq, 1'b1);
        ack = 1'b1; step(); ack = 1'b0;
        chk_out("single.ack", 1'b0, 2'd0, 4'b0000, 1'b1);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk_out("single.eoi", 1'b0, 2'd0, 4'b0000, 1'b0);

        // Priority: simultaneous edges on 3 and 1, lowest index served first.
        write_mask(4'b1111);
        src = 4'b1010; step(); src = 4'b0000;
        chk("prio.pend", pending, 4'b1010);
        step();
        chk_out("prio.first", 1'b1, 2'd1, 4'b1010, 1'b0);
        ack = 1'b1; step(); ack = 1'b0;
        chk_out("prio.ack1", 1'b0, 2'd1, 4'b1000, 1'b1);
        eoi = 1'b1; step(); eoi = 1'b0;
        chk("prio.gap.irq", irq, 1'b0);
        step();
        chk_out("prio.second", 1'b1, 2'd3, 4'b1000, 1'b0);
        ack = 1'b1; step(); ack = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;
        chk_out("prio.done", 1'b0, 2'd3, 4'b0000, 1'b0);

        // Masking: pending latches while masked, request appears after enabling.
        write_mask(4'b0000);
        src = 4'b0100; step(); src = 4'b0000;
        step(); step();
        chk_out("mask.latched", 1'b0, 2'd3, 4'b0100, 1'b0);
        write_mask(4'b0100);
        chk("mask.write.irq", irq, 1'b0);
        step();
        chk_out("mask.req", 1'b1, 2'd2, 4'b0100, 1'b0);
        ack = 1'b1; step(); ack = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;

        // Set wins: new edge on src[0] in the same cycle as its ack.
        write_mask(4'b0001);
        src = 4'b0001; step(); src = 4'b0000;
        step();
        chk_out("setwin.req", 1'b1, 2'd0, 4'b0001, 1'b0);
        ack = 1'b1; src = 4'b0001; step(); ack = 1'b0; src = 4'b0000;
        chk_out("setwin.ack", 1'b0, 2'd0, 4'b0001, 1'b1);
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
        chk_out("setwin.rereq", 1'b1, 2'd0, 4'b0001, 1'b0);

        // Protocol: eoi in REQ ignored; edge during SERV latched; reset mid-SERV clears all.
        eoi = 1'b1; step(); eoi = 1'b0;
        chk_out("proto.eoi_in_req", 1'b1, 2'd0, 4'b0001, 1'b0);
        ack = 1'b1; step(); ack = 1'b0;
        chk("proto.serv", in_service, 1'b1);
        src = 4'b0010; step();
        chk("proto.serv.pend", pending, 4'b0010);
        reset = 1'b1; src = 4'b0011; step();
        chk_out("proto.reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        reset = 1'b0; step(); step();
        chk_out("proto.held_src", 1'b0, 2'd0, 4'b0000, 1'b0);

        // ack in IDLE must not move the FSM or touch pending.
        write_mask(4'b0000);
        src = 4'b0000; step();
        src = 4'b1000; step(); src = 4'b0000;
        ack = 1'b1; step(); ack = 1'b0;
        chk_out("proto.ack_idle", 1'b0, 2'd0, 4'b1000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
